petri_engine: RTL and testbench

- Parametrised Petri-net execution engine; successor to the fixed, generated per-net token-game blocks.
- The net topology comes from parameters: input, output and inhibitor arcs, arc weights, and the initial marking.
- Adds the following, none of which the fixed blocks have:
  - bulk or single firing mode;
  - fixed-priority or round-robin arbitration;
  - run/step/halt control;
  - marking load and readout;
  - deadlock and overflow detection.
- Drives board LEDs from one selected place, and is the building block for all future net simulations on the FPGA.

---
 rtl/petri_engine.sv | 209 ++++++++++++++++++++
 tb/tb_petri_engine.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/petri_engine.sv
// Parametrised Petri-net token-game engine: enable/fire-count evaluation, arbitration,
// single-cycle marking update with saturation, run/step/halt control and marking load/readout.
module petri_engine #(
  parameter int NP = 5,
  parameter int NT = 3,
  parameter int TW = 8,
  parameter int WW = 4,
  parameter logic [NT*NP*WW-1:0] PRE  = '0,
  parameter logic [NT*NP*WW-1:0] POST = '0,
  parameter logic [NT*NP-1:0]    INH  = '0,
  parameter logic [NP*TW-1:0]    INIT = '0,
  parameter bit BULK      = 1'b1,
  parameter bit ARB_RR    = 1'b0,
  parameter int LED_PLACE = 1,
  localparam int PIW = (NP > 1) ? $clog2(NP) : 1,
  localparam int TIW = (NT > 1) ? $clog2(NT) : 1
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  input  logic           run,
  input  logic           step,
  input  logic           load_en,
  input  logic [PIW-1:0] load_idx,
  input  logic [TW-1:0]  load_val,
  input  logic [PIW-1:0] rd_idx,
  output logic [TW-1:0]  rd_val,
  output logic           fired,
  output logic [TIW-1:0] fired_idx,
  output logic [TW-1:0]  fire_cnt,
  output logic           busy,
  output logic           deadlock,
  output logic           overflow,
  output logic [31:0]    step_count,
  output logic [5:0]     led
);

  // state | meaning
  // IDLE  | halted; load and single step accepted
  // RUN   | one firing per cycle while run is high
  // DEAD  | nothing enabled during RUN; waits for run to drop
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;

  localparam int AW = TW + WW + TW;
  localparam int CW = (TW > WW) ? TW : WW;
  localparam logic [TW-1:0] MAXT = '1;

  state_t         state, state_nxt;
  logic [TW-1:0]  m      [NP];
  logic [TW-1:0]  m_fire [NP];
  logic [TW-1:0]  m_nxt  [NP];
  logic [AW-1:0]  sum    [NP];
  logic [TW-1:0]  k_t    [NT];
  logic [NT-1:0]  en;
  logic [NT-1:0]  has_in;
  logic [TIW-1:0] ptr;
  logic [TIW-1:0] win;
  logic [TW-1:0]  k_win;
  logic           found;
  logic           any_en;
  logic           ovf_hit;
  logic           do_fire;
  logic           do_load;
  logic           set_dead;

  function automatic logic [WW-1:0] pre_w(int t, int p);
    return PRE[(t*NP+p)*WW +: WW];
  endfunction

  function automatic logic [WW-1:0] post_w(int t, int p);
    return POST[(t*NP+p)*WW +: WW];
  endfunction

  function automatic logic [5:0] led_of(logic [TW-1:0] v);
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < 6; i++)
      if (i < TW) r[i] = v[i];
    return ~r;
  endfunction

  // Enable and bulk fire count per transition, straight from the current marking
  always_comb begin
    for (int t = 0; t < NT; t++) begin
      en[t]     = 1'b1;
      has_in[t] = 1'b0;
      k_t[t]    = MAXT;
      for (int p = 0; p < NP; p++) begin
        if (pre_w(t, p) != '0) begin
          has_in[t] = 1'b1;
          if (CW'(m[p]) < CW'(pre_w(t, p))) en[t] = 1'b0;
          if (TW'(CW'(m[p]) / CW'(pre_w(t, p))) < k_t[t])
            k_t[t] = TW'(CW'(m[p]) / CW'(pre_w(t, p)));
        end
        if (INH[t*NP+p] && (m[p] != '0)) en[t] = 1'b0;
      end
      if (!has_in[t] || !BULK) k_t[t] = TW'(1);
    end
  end

  always_comb begin
    win   = '0;
    found = 1'b0;
    if (ARB_RR) begin
      for (int i = 0; i < NT; i++)
        if (!found && en[(int'(ptr) + i) % NT]) begin
          win   = TIW'((int'(ptr) + i) % NT);
          found = 1'b1;
        end
    end else begin
      for (int i = NT - 1; i >= 0; i--)
        if (en[i]) win = TIW'(i);
    end
  end

  assign any_en = |en;
  assign k_win  = k_t[win];

  // Subtraction cannot underflow because k never exceeds floor(m/w) on any input arc
  always_comb begin
    ovf_hit = 1'b0;
    for (int p = 0; p < NP; p++) begin
      sum[p] = AW'(m[p]) - AW'(k_win) * AW'(pre_w(int'(win), p))
             + AW'(k_win) * AW'(post_w(int'(win), p));
      if (sum[p] > AW'(MAXT)) begin
        m_fire[p] = MAXT;
        ovf_hit   = 1'b1;
      end else begin
        m_fire[p] = sum[p][TW-1:0];
      end
      m_nxt[p] = m[p];
      if (do_fire)
        m_nxt[p] = m_fire[p];
      else if (do_load && (int'(load_idx) == p))
        m_nxt[p] = load_val;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (run) state_nxt = S_RUN;
      S_RUN:   if (!run) state_nxt = S_IDLE;
               else if (!any_en) state_nxt = S_DEAD;
      S_DEAD:  if (!run) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // load_en outranks step; an out-of-range load is dropped entirely
  always_comb begin
    do_fire  = 1'b0;
    do_load  = 1'b0;
    set_dead = 1'b0;
    case (state)
      S_IDLE:
        if (!run) begin
          if (load_en) begin
            do_load = (int'(load_idx) < NP);
          end else if (step) begin
            do_fire  = any_en;
            set_dead = !any_en;
          end
        end
      S_RUN:
        if (run) begin
          do_fire  = any_en;
          set_dead = !any_en;
        end
      default: ;
    endcase
  end

  assign busy = (state == S_RUN);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int p = 0; p < NP; p++) m[p] <= INIT[p*TW +: TW];
      ptr        <= '0;
      fired      <= 1'b0;
      fired_idx  <= '0;
      fire_cnt   <= '0;
      deadlock   <= 1'b0;
      overflow   <= 1'b0;
      step_count <= '0;
      rd_val     <= '0;
      led        <= led_of(INIT[LED_PLACE*TW +: TW]);
    end else begin
      for (int p = 0; p < NP; p++) m[p] <= m_nxt[p];
      fired <= do_fire;
      if (do_fire) begin
        fired_idx  <= win;
        fire_cnt   <= k_win;
        step_count <= step_count + 32'd1;
        if (ARB_RR) ptr <= (win == TIW'(NT - 1)) ? '0 : win + 1'b1;
      end
      if (do_fire && ovf_hit) overflow <= 1'b1;
      if (set_dead)     deadlock <= 1'b1;
      else if (do_load) deadlock <= 1'b0;
      rd_val <= (int'(rd_idx) < NP) ? m_nxt[rd_idx] : '0;
      led    <= led_of(m_nxt[LED_PLACE]);
    end
  end

endmodule

// File: tb/tb_petri_engine.sv
// Scoreboard bench: four engine instances (bulk, single, round-robin, overflow) checked
// against hand-computed firing sequences and final markings.
module tb_petri_engine;

  localparam logic [59:0] A_PRE  = (60'd1 << 0) | (60'd1 << 32) | (60'd1 << 56);
  localparam logic [59:0] A_POST = (60'd1 << 4) | (60'd1 << 24) | (60'd1 << 48);
  localparam logic [14:0] A_INH  = (15'd1 << 2) | (15'd1 << 7) | (15'd1 << 10)
                                 | (15'd1 << 12) | (15'd1 << 13);
  localparam logic [39:0] A_INIT = {8'd1, 8'd5, 8'd0, 8'd0, 8'd12};

  typedef struct {int idx; int cnt;} ev_t;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic       sys_rst;
  logic [3:0] run_v, step_v, load_v;
  logic [2:0] lidx5, rd5;
  logic [7:0] lval;
  logic       rd2;

  logic [7:0] b_rd, s_rd, r_rd;
  logic [3:0] o_rd, o_cnt;
  logic [7:0] b_cnt, s_cnt, r_cnt;
  logic [1:0] b_idx, s_idx;
  logic [0:0] r_idx, o_idx;
  logic       b_fired, s_fired, r_fired, o_fired;
  logic       b_busy, s_busy, r_busy, o_busy;
  logic       b_dead, s_dead, r_dead, o_dead;
  logic       b_ovf, s_ovf, r_ovf, o_ovf;
  logic [31:0] b_sc, s_sc, r_sc, o_sc;
  logic [5:0] b_led, s_led, r_led, o_led;

  int checks = 0;
  int errors = 0;
  ev_t q_b[$], q_s[$], q_r[$], q_o[$];

  petri_engine #(.NP(5), .NT(3), .PRE(A_PRE), .POST(A_POST), .INH(A_INH), .INIT(A_INIT),
                 .BULK(1'b1)) u_bulk (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .run(run_v[0]), .step(step_v[0]),
    .load_en(load_v[0]), .load_idx(lidx5), .load_val(lval), .rd_idx(rd5), .rd_val(b_rd),
    .fired(b_fired), .fired_idx(b_idx), .fire_cnt(b_cnt), .busy(b_busy), .deadlock(b_dead),
    .overflow(b_ovf), .step_count(b_sc), .led(b_led));

  petri_engine #(.NP(5), .NT(3), .PRE(A_PRE), .POST(A_POST), .INH(A_INH), .INIT(A_INIT),
                 .BULK(1'b0)) u_single (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .run(run_v[1]), .step(step_v[1]),
    .load_en(load_v[1]), .load_idx(lidx5), .load_val(lval), .rd_idx(rd5), .rd_val(s_rd),
    .fired(s_fired), .fired_idx(s_idx), .fire_cnt(s_cnt), .busy(s_busy), .deadlock(s_dead),
    .overflow(s_ovf), .step_count(s_sc), .led(s_led));

  petri_engine #(.NP(2), .NT(2), .PRE(16'h0101), .POST(16'h1010), .INH(4'b0),
                 .INIT({8'd0, 8'd4}), .BULK(1'b0), .ARB_RR(1'b1)) u_rr (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .run(run_v[2]), .step(step_v[2]),
    .load_en(load_v[2]), .load_idx(1'b0), .load_val(8'd0), .rd_idx(rd2), .rd_val(r_rd),
    .fired(r_fired), .fired_idx(r_idx), .fire_cnt(r_cnt), .busy(r_busy), .deadlock(r_dead),
    .overflow(r_ovf), .step_count(r_sc), .led(r_led));

  petri_engine #(.NP(2), .NT(1), .TW(4), .PRE(8'h01), .POST(8'h10), .INH(2'b0),
                 .INIT(8'h8C), .BULK(1'b1)) u_ovf (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .run(run_v[3]), .step(step_v[3]),
    .load_en(load_v[3]), .load_idx(1'b0), .load_val(4'd0), .rd_idx(rd2), .rd_val(o_rd),
    .fired(o_fired), .fired_idx(o_idx), .fire_cnt(o_cnt), .busy(o_busy), .deadlock(o_dead),
    .overflow(o_ovf), .step_count(o_sc), .led(o_led));

  function automatic ev_t mk(int i, int c);
    ev_t e;
    e.idx = i;
    e.cnt = c;
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic ev_cmp(string nm, bit empty, ev_t e, int ai, int ac);
    checks++;
    if (empty) begin
      errors++;
      $display("FAIL %s: unexpected firing idx=%0d k=%0d", nm, ai, ac);
    end else if (ai != e.idx || ac != e.cnt) begin
      errors++;
      $display("FAIL %s: got idx=%0d k=%0d expected idx=%0d k=%0d", nm, ai, ac, e.idx, e.cnt);
    end
  endtask

  // Monitor: every fired pulse consumes one expected firing from its instance's queue
  always @(negedge sys_clk) begin
    if (b_fired) begin
      if (q_b.size() == 0) ev_cmp("fire_bulk", 1'b1, mk(0, 0), int'(b_idx), int'(b_cnt));
      else ev_cmp("fire_bulk", 1'b0, q_b.pop_front(), int'(b_idx), int'(b_cnt));
    end
    if (s_fired) begin
      if (q_s.size() == 0) ev_cmp("fire_single", 1'b1, mk(0, 0), int'(s_idx), int'(s_cnt));
      else ev_cmp("fire_single", 1'b0, q_s.pop_front(), int'(s_idx), int'(s_cnt));
    end
    if (r_fired) begin
      if (q_r.size() == 0) ev_cmp("fire_rr", 1'b1, mk(0, 0), int'(r_idx), int'(r_cnt));
      else ev_cmp("fire_rr", 1'b0, q_r.pop_front(), int'(r_idx), int'(r_cnt));
    end
    if (o_fired) begin
      if (q_o.size() == 0) ev_cmp("fire_ovf", 1'b1, mk(0, 0), int'(o_idx), int'(o_cnt));
      else ev_cmp("fire_ovf", 1'b0, q_o.pop_front(), int'(o_idx), int'(o_cnt));
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_a[5];
    exp_a = '{0, 17, 1, 0, 0};
    sys_rst = 1'b1;
    run_v = '0; step_v = '0; load_v = '0;
    lidx5 = '0; lval = '0; rd5 = '0; rd2 = 1'b0;
    tick();
    tick();
    sys_rst = 1'b0;

    chk("rst_fired", b_fired, 0);
    chk("rst_dead", b_dead, 0);
    chk("rst_sc", b_sc, 0);
    chk("rst_led", b_led, 6'h3F);
    chk("rst_busy", b_busy, 0);

    // All four nets run to deadlock together
    q_b.push_back(mk(0, 12)); q_b.push_back(mk(1, 5)); q_b.push_back(mk(2, 1));
    for (int i = 0; i < 12; i++) q_s.push_back(mk(0, 1));
    for (int i = 0; i < 5; i++) q_s.push_back(mk(1, 1));
    q_s.push_back(mk(2, 1));
    for (int i = 0; i < 4; i++) q_r.push_back(mk(i % 2, 1));
    q_o.push_back(mk(0, 12));
    run_v = 4'b1111;
    repeat (25) tick();

    chk("bulk_dead", b_dead, 1);   chk("bulk_busy", b_busy, 0);
    chk("bulk_sc", b_sc, 3);       chk("bulk_led", b_led, 6'b101110);
    chk("bulk_ovf", b_ovf, 0);
    chk("single_dead", s_dead, 1); chk("single_sc", s_sc, 18);
    chk("single_led", s_led, 6'b101110);
    chk("rr_dead", r_dead, 1);     chk("rr_sc", r_sc, 4);
    chk("ovf_flag", o_ovf, 1);     chk("ovf_dead", o_dead, 1);
    chk("ovf_led", o_led, 6'b110000);
    for (int p = 0; p < 5; p++) begin
      rd5 = 3'(p);
      tick();
      chk("bulk_mark", b_rd, 32'(exp_a[p]));
      chk("single_mark", s_rd, 32'(exp_a[p]));
    end
    rd2 = 1'b0; tick();
    chk("rr_p0", r_rd, 0);  chk("ovf_p0", o_rd, 0);
    rd2 = 1'b1; tick();
    chk("rr_p1", r_rd, 4);  chk("ovf_p1", o_rd, 15);
    chk("q_single_empty", q_s.size(), 0);
    chk("q_rr_empty", q_r.size(), 0);

    // Reset in the middle of a RUN
    run_v = '0; tick();
    load_v = 4'b0001; lidx5 = 3'd0; lval = 8'd3; tick();
    lidx5 = 3'd2; lval = 8'd0; tick();
    load_v = '0;
    chk("load_clears_dead", b_dead, 0);
    q_b.push_back(mk(0, 3));
    run_v[0] = 1'b1; tick();
    chk("run_busy", b_busy, 1);
    tick();
    chk("run_sc", b_sc, 4);
    sys_rst = 1'b1; run_v = '0; tick();
    sys_rst = 1'b0;
    chk("mid_rst_fired", b_fired, 0);  chk("mid_rst_sc", b_sc, 0);
    chk("mid_rst_dead", b_dead, 0);    chk("mid_rst_busy", b_busy, 0);
    chk("mid_rst_led", b_led, 6'h3F);  chk("mid_rst_rd", b_rd, 0);
    chk("mid_rst_sdead", s_dead, 0);   chk("mid_rst_oovf", o_ovf, 0);
    rd5 = 3'd0; tick();
    chk("mid_rst_p0", b_rd, 12);
    rd5 = 3'd1; tick();
    chk("mid_rst_p1", b_rd, 0);

    // Load wins over a simultaneous step, then a lone step fires once
    rd5 = 3'd3;
    load_v[0] = 1'b1; lidx5 = 3'd3; lval = 8'd7; step_v[0] = 1'b1; tick();
    load_v = '0; step_v = '0;
    chk("load_step_fired", b_fired, 0);
    chk("load_step_sc", b_sc, 0);
    chk("load_rd", b_rd, 7);
    q_b.push_back(mk(0, 12));
    step_v[0] = 1'b1; tick();
    step_v = '0;
    chk("step_sc", b_sc, 1);
    rd5 = 3'd1; tick();
    chk("step_p1", b_rd, 12);
    chk("step_once", b_sc, 1);

    // load_en while running is ignored
    q_b.push_back(mk(1, 7)); q_b.push_back(mk(2, 1));
    run_v[0] = 1'b1; load_v[0] = 1'b1; lidx5 = 3'd0; lval = 8'd9;
    repeat (6) tick();
    load_v = '0; tick();
    chk("run_load_dead", b_dead, 1);
    chk("run_load_sc", b_sc, 3);
    rd5 = 3'd0; tick();
    chk("run_load_p0", b_rd, 0);
    run_v = '0; tick();
    rd5 = 3'd1; tick();
    chk("run_load_p1", b_rd, 19);

    // A step with nothing enabled sets deadlock while staying IDLE
    load_v[0] = 1'b1; lidx5 = 3'd2; lval = 8'd0; tick();
    load_v = '0;
    chk("reload_dead", b_dead, 0);
    step_v[0] = 1'b1; tick();
    step_v = '0;
    chk("dead_step", b_dead, 1);
    chk("dead_step_sc", b_sc, 3);
    chk("dead_step_busy", b_busy, 0);
    tick();
    chk("q_bulk_empty", q_b.size(), 0);
    chk("q_ovf_empty", q_o.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
